scoreboard_grf: RTL and testbench

SCOREBOARD_GRF -- requirements
Module: scoreboard_grf

---
 rtl/scoreboard_grf_pkg.sv | 13 +
 rtl/scoreboard_grf_read_port.sv | 37 +++
 rtl/scoreboard_grf.sv | 109 ++++++++++
 tb/tb_scoreboard_grf.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_grf_pkg.sv
// Shared CPU constants for the general register file scoreboard.
package scoreboard_grf_pkg;

    localparam int GRF_DATA_W = 32;
    localparam int GRF_ADDR_W = 5;
    localparam int GRF_NRD    = 2;

    // Low bit of lane k when lanes of width w are packed side by side.
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/scoreboard_grf_read_port.sv
// One register-file read port: same-cycle bypass mux plus busy reporting.
module grf_read_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              blank,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] stored,
    input  logic              pend,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data,
    output logic              busy
);

    // Port A beats port B beats storage; index 0 and reset read as zero.
    always_comb begin
        data = '0;
        busy = 1'b0;
        if (!blank && addr != '0) begin
            if (wa_en && wa_addr == addr) begin
                data = wa_data;
            end else if (wb_en && wb_addr == addr) begin
                data = wb_data;
            end else begin
                data = stored;
            end
            // A result landing this cycle is already visible through the bypass.
            busy = pend && !(wb_en && wb_addr == addr);
        end
    end

endmodule

// File: rtl/scoreboard_grf.sv
// Register file with pending-result scoreboard for long-latency writebacks.
module scoreboard_grf
    import scoreboard_grf_pkg::*;
#(
    parameter int DATA_W = GRF_DATA_W,
    parameter int ADDR_W = GRF_ADDR_W,
    parameter int NRD    = GRF_NRD
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  wa_en,
    input  logic [ADDR_W-1:0]     wa_addr,
    input  logic [DATA_W-1:0]     wa_data,
    input  logic                  wb_en,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    output logic                  any_busy,
    output logic                  sb_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pend_nxt;
    logic              err_now;

    // Register storage; port B is assigned first so port A wins a same-index collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wb_en && wb_addr != '0) begin
                regs[wb_addr] <= wb_data;
            end
            if (wa_en && wa_addr != '0) begin
                regs[wa_addr] <= wa_data;
            end
        end
    end

    // Next pending vector: writeback clears, issue sets afterwards so issue wins.
    always_comb begin
        pend_nxt = pending;
        if (wb_en && wb_addr != '0) begin
            pend_nxt[wb_addr] = 1'b0;
        end
        if (iss_en && iss_addr != '0) begin
            pend_nxt[iss_addr] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    // Hazards: re-issue to a still-pending register, or writeback with nothing pending.
    always_comb begin
        err_now = 1'b0;
        if (iss_en && iss_addr != '0 && pending[iss_addr]
            && !(wb_en && wb_addr == iss_addr)) begin
            err_now = 1'b1;
        end
        if (wb_en && wb_addr != '0 && !pending[wb_addr]) begin
            err_now = 1'b1;
        end
    end

    // Pending bits and the sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            sb_err  <= 1'b0;
        end else begin
            pending <= pend_nxt;
            sb_err  <= sb_err | err_now;
        end
    end

    assign any_busy = |pending;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = rd_addr[slice_lo(k, ADDR_W) +: ADDR_W];

        grf_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_port (
            .blank   (reset),
            .addr    (addr),
            .stored  (regs[addr]),
            .pend    (pending[addr]),
            .wa_en   (wa_en),
            .wa_addr (wa_addr),
            .wa_data (wa_data),
            .wb_en   (wb_en),
            .wb_addr (wb_addr),
            .wb_data (wb_data),
            .data    (rd_data[slice_lo(k, DATA_W) +: DATA_W]),
            .busy    (rd_busy[k])
        );
    end

endmodule

// File: tb/tb_scoreboard_grf.sv
// Directed bench for scoreboard_grf with an expectation queue.
module tb_scoreboard_grf;

    logic        clk;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wa_en;
    logic [4:0]  wa_addr;
    logic [31:0] wa_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        any_busy;
    logic        sb_err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];

    scoreboard_grf dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wa_en    (wa_en),
        .wa_addr  (wa_addr),
        .wa_data  (wa_data),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .any_busy (any_busy),
        .sb_err   (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        q.push_back(e);
    endtask

    task automatic expect_all(input string tag, input logic [31:0] rd0, input logic [31:0] rd1,
                              input logic [1:0] busy, input logic any, input logic err);
        push({tag, ".rd0"}, rd0);
        push({tag, ".rd1"}, rd1);
        push({tag, ".busy"}, {30'b0, busy});
        push({tag, ".any"}, {31'b0, any});
        push({tag, ".err"}, {31'b0, err});
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $error("FAIL queue_empty observed=%h expected=<entry>", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.val) else begin
                fails++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic compare_all();
        pop_chk(rd_data[31:0]);
        pop_chk(rd_data[63:32]);
        pop_chk({30'b0, rd_busy});
        pop_chk({31'b0, any_busy});
        pop_chk({31'b0, sb_err});
    endtask

    initial begin
        reset    = 1'b1;
        wb_en    = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        // Activity during reset must be ignored and not visible on the outputs.
        rd_addr  = {5'd0, 5'd5};
        wa_en    = 1'b1;
        wa_addr  = 5'd5;
        wa_data  = 32'h1234_5678;
        iss_en   = 1'b1;
        iss_addr = 5'd3;
        step();
        step();
        expect_all("rst", 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
        compare_all();

        wa_en   = 1'b0;
        iss_en  = 1'b0;
        reset   = 1'b0;
        rd_addr = {5'd3, 5'd5};
        #1;
        expect_all("post_rst", 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
        compare_all();

        // Port A write with same-cycle bypass, then stored value.
        rd_addr = {5'd0, 5'd5};
        wa_en   = 1'b1;
        wa_addr = 5'd5;
        wa_data = 32'h1234_5678;
        #1;
        expect_all("byp_a", 32'h1234_5678, 32'h0, 2'b00, 1'b0, 1'b0);
        compare_all();
        step();
        wa_en = 1'b0;
        #1;
        expect_all("stored5", 32'h1234_5678, 32'h0, 2'b00, 1'b0, 1'b0);
        compare_all();

        // Issue 7, then collide port A and port B on 7.
        iss_en   = 1'b1;
        iss_addr = 5'd7;
        rd_addr  = {5'd7, 5'd5};
        #1;
        expect_all("iss7_pre", 32'h1234_5678, 32'h0, 2'b00, 1'b0, 1'b0);
        compare_all();
        step();
        iss_en = 1'b0;
        #1;
        expect_all("iss7", 32'h1234_5678, 32'h0, 2'b10, 1'b1, 1'b0);
        compare_all();
        wa_en   = 1'b1;
        wa_addr = 5'd7;
        wa_data = 32'hAAAA_AAAA;
        wb_en   = 1'b1;
        wb_addr = 5'd7;
        wb_data = 32'h5555_5555;
        #1;
        expect_all("wab7", 32'h1234_5678, 32'hAAAA_AAAA, 2'b00, 1'b1, 1'b0);
        compare_all();
        step();
        wa_en = 1'b0;
        wb_en = 1'b0;
        #1;
        expect_all("after7", 32'h1234_5678, 32'hAAAA_AAAA, 2'b00, 1'b0, 1'b0);
        compare_all();

        // Issue 9, then long-latency writeback of 9.
        iss_en   = 1'b1;
        iss_addr = 5'd9;
        step();
        iss_en  = 1'b0;
        rd_addr = {5'd7, 5'd9};
        #1;
        expect_all("busy9", 32'h0, 32'hAAAA_AAAA, 2'b01, 1'b1, 1'b0);
        compare_all();
        wb_en   = 1'b1;
        wb_addr = 5'd9;
        wb_data = 32'hDEAD_BEEF;
        #1;
        expect_all("wb9", 32'hDEAD_BEEF, 32'hAAAA_AAAA, 2'b00, 1'b1, 1'b0);
        compare_all();
        step();
        wb_en = 1'b0;
        #1;
        expect_all("done9", 32'hDEAD_BEEF, 32'hAAAA_AAAA, 2'b00, 1'b0, 1'b0);
        compare_all();

        // Index 0 is inert for every port.
        rd_addr  = {5'd0, 5'd0};
        wa_en    = 1'b1;
        wa_addr  = 5'd0;
        wa_data  = 32'hFFFF_FFFF;
        wb_en    = 1'b1;
        wb_addr  = 5'd0;
        wb_data  = 32'h1111_1111;
        iss_en   = 1'b1;
        iss_addr = 5'd0;
        #1;
        expect_all("zero_byp", 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
        compare_all();
        step();
        wa_en  = 1'b0;
        wb_en  = 1'b0;
        iss_en = 1'b0;
        #1;
        expect_all("zero_after", 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
        compare_all();

        // Issue and writeback together keep the bit set without error.
        rd_addr  = {5'd0, 5'd9};
        iss_en   = 1'b1;
        iss_addr = 5'd9;
        step();
        iss_en = 1'b0;
        #1;
        expect_all("iss9b", 32'hDEAD_BEEF, 32'h0, 2'b01, 1'b1, 1'b0);
        compare_all();
        iss_en  = 1'b1;
        wb_en   = 1'b1;
        wb_addr = 5'd9;
        wb_data = 32'h0000_0001;
        #1;
        expect_all("iss_wb9", 32'h0000_0001, 32'h0, 2'b00, 1'b1, 1'b0);
        compare_all();
        step();
        iss_en = 1'b0;
        wb_en  = 1'b0;
        #1;
        expect_all("iss_wins", 32'h0000_0001, 32'h0, 2'b01, 1'b1, 1'b0);
        compare_all();

        // Second issue to a pending register is a hazard, and it sticks.
        iss_en = 1'b1;
        step();
        iss_en = 1'b0;
        #1;
        expect_all("dbl_iss", 32'h0000_0001, 32'h0, 2'b01, 1'b1, 1'b1);
        compare_all();
        step();
        expect_all("err_held", 32'h0000_0001, 32'h0, 2'b01, 1'b1, 1'b1);
        compare_all();

        // Asynchronous reset while registers are pending.
        iss_en   = 1'b1;
        iss_addr = 5'd11;
        step();
        iss_en  = 1'b0;
        rd_addr = {5'd11, 5'd9};
        #1;
        expect_all("pre_rst", 32'h0000_0001, 32'h0, 2'b11, 1'b1, 1'b1);
        compare_all();
        #2;
        reset = 1'b1;
        #1;
        expect_all("async_rst", 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
        compare_all();
        step();
        reset = 1'b0;
        #1;
        expect_all("rst_clr", 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
        compare_all();

        // Writeback for a result lost to reset raises the error.
        wb_en   = 1'b1;
        wb_addr = 5'd9;
        wb_data = 32'h0000_0077;
        #1;
        expect_all("late_wb", 32'h0000_0077, 32'h0, 2'b00, 1'b0, 1'b0);
        compare_all();
        step();
        wb_en = 1'b0;
        #1;
        expect_all("late_err", 32'h0000_0077, 32'h0, 2'b00, 1'b0, 1'b1);
        compare_all();

        if (q.size() != 0) begin
            tests++;
            fails++;
            $error("FAIL queue_left observed=%0d expected=0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
